isa_io_write_decoder: RTL and testbench

- Front-end stage that feeds the `Register` banks on the riser.
- Watches the asynchronous ISA I/O write bus (SA, SD, IOW#, AEN) and synchronises it into the `clk` domain.
- Decodes writes that fall inside a base-address window.
- For each accepted write, presents the write data on a shared bus with a one-hot, single-cycle load strobe, one strobe per downstream register. It also rejects glitches and DMA cycles.

---
 rtl/isa_io_write_decoder.sv | 133 +++++++++++++
 tb/tb_isa_io_write_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/isa_io_write_decoder.sv
// rtl/isa_io_write_decoder.sv - ISA I/O write decoder: synchronises the bus, decodes a window, emits one-hot load strobes
module isa_io_write_decoder #(
    parameter int BASE_ADDR  = 'h220,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int MIN_LOW    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       sa,
    input  logic [DATA_WIDTH-1:0]       sd,
    input  logic                        iow_n,
    input  logic                        aen,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [NUM_REGS-1:0]         load,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        reject,
    input  logic                        clr_reject
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(MIN_LOW + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CNT_W-1:0]      MIN_CNT = CNT_W'(MIN_LOW);

    typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

    logic                  iow_m_q, iow_s_q, aen_m_q, aen_s_q;
    logic [ADDR_WIDTH-1:0] sa_m_q, sa_s_q;
    logic [DATA_WIDTH-1:0] sd_m_q, sd_s_q;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [NUM_REGS-1:0]   load_q, load_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0]      wr_index_q, wr_index_d;
    logic                  reject_q, reject_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  hit;
    logic [IDX_W-1:0]      sa_idx;

    // Modulo subtraction makes a window at the top of the space wrap naturally.
    assign offset = sa_s_q - BASE_A;
    assign hit    = (offset[ADDR_WIDTH-1:IDX_W] == '0);
    assign sa_idx = sa_s_q[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dat_d      = dat_q;
        load_d     = '0;
        wr_data_d  = wr_data_q;
        wr_index_d = wr_index_q;
        reject_d   = clr_reject ? 1'b0 : reject_q;
        case (state_q)
            IDLE: begin
                if (!iow_s_q && !aen_s_q && hit) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_W'(1);
                    idx_d   = sa_idx;
                    dat_d   = sd_s_q;
                end
            end
            ACTIVE: begin
                if (aen_s_q) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else if (!iow_s_q) begin
                    idx_d = sa_idx;
                    dat_d = sd_s_q;
                    if (cnt_q < MIN_CNT) cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_q >= MIN_CNT) begin
                    state_d       = COMMIT;
                    load_d[idx_q] = 1'b1;
                    wr_data_d     = dat_q;
                    wr_index_d    = idx_q;
                end else begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iow_m_q    <= 1'b1;
            iow_s_q    <= 1'b1;
            aen_m_q    <= 1'b1;
            aen_s_q    <= 1'b1;
            sa_m_q     <= '0;
            sa_s_q     <= '0;
            sd_m_q     <= '0;
            sd_s_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            dat_q      <= '0;
            load_q     <= '0;
            wr_data_q  <= '0;
            wr_index_q <= '0;
            reject_q   <= 1'b0;
        end else begin
            iow_m_q    <= iow_n;
            iow_s_q    <= iow_m_q;
            aen_m_q    <= aen;
            aen_s_q    <= aen_m_q;
            sa_m_q     <= sa;
            sa_s_q     <= sa_m_q;
            sd_m_q     <= sd;
            sd_s_q     <= sd_m_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dat_q      <= dat_d;
            load_q     <= load_d;
            wr_data_q  <= wr_data_d;
            wr_index_q <= wr_index_d;
            reject_q   <= reject_d;
        end
    end

    assign wr_data  = wr_data_q;
    assign load     = load_q;
    assign wr_index = wr_index_q;
    assign reject   = reject_q;
endmodule

// File: tb/tb_isa_io_write_decoder.sv
// tb/tb_isa_io_write_decoder.sv - scoreboard bench for isa_io_write_decoder
module tb_isa_io_write_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  sa = '0;
    logic [7:0]  sd = '0;
    logic        iow_n = 1'b1;
    logic        aen = 1'b1;
    logic        clr_reject = 1'b0;
    logic [7:0]  wr_data;
    logic [15:0] load;
    logic [3:0]  wr_index;
    logic        reject;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] load;
        logic [7:0]  data;
        logic [3:0]  idx;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    isa_io_write_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .sa         (sa),
        .sd         (sd),
        .iow_n      (iow_n),
        .aen        (aen),
        .wr_data    (wr_data),
        .load       (load),
        .wr_index   (wr_index),
        .reject     (reject),
        .clr_reject (clr_reject)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with a load strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (load !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got 0x%0h, expected 0x0 at cycle %0d", load, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("load_onehot", load, e.load);
                check("load_data", wr_data, e.data);
                check("load_index", wr_index, e.idx);
                check("load_latency", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // iow_n is held low for 'low' edges; a committed write is expected 3 edges after it rises.
    task automatic isa_write(input logic [9:0] a, input logic [7:0] d, input int low,
                             input bit commit, input logic [15:0] exp_load, input logic [3:0] exp_idx,
                             input int gap);
        exp_t e;
        sa = a;
        sd = d;
        iow_n = 1'b0;
        idle(low);
        iow_n = 1'b1;
        if (commit) begin
            e.load = exp_load;
            e.data = d;
            e.idx  = exp_idx;
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
        end
        idle(gap);
    endtask

    initial begin
        #12;
        check("reset_wr_data", wr_data, 8'h00);
        check("reset_load", load, 16'h0000);
        check("reset_wr_index", wr_index, 4'd0);
        check("reset_reject", reject, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        aen = 1'b0;
        idle(4);

        // basic write
        isa_write(10'h22C, 8'hA5, 6, 1'b1, 16'h1000, 4'd12, 6);
        check("basic_wr_data", wr_data, 8'hA5);
        check("basic_wr_index", wr_index, 4'd12);
        check("basic_reject", reject, 1'b0);

        // out of window, both sides
        isa_write(10'h230, 8'h5A, 6, 1'b0, 16'h0, 4'd0, 6);
        isa_write(10'h21F, 8'h3C, 6, 1'b0, 16'h0, 4'd0, 6);
        check("oow_wr_data", wr_data, 8'hA5);
        check("oow_wr_index", wr_index, 4'd12);
        check("oow_reject", reject, 1'b0);

        // glitch shorter than MIN_LOW
        isa_write(10'h226, 8'h77, 1, 1'b0, 16'h0, 4'd0, 6);
        check("glitch_reject", reject, 1'b1);
        check("glitch_wr_data", wr_data, 8'hA5);
        clr_reject = 1'b1;
        idle(1);
        clr_reject = 1'b0;
        check("clr_reject", reject, 1'b0);

        // DMA cycle ignored
        aen = 1'b1;
        isa_write(10'h220, 8'h99, 6, 1'b0, 16'h0, 4'd0, 4);
        check("dma_ignored_reject", reject, 1'b0);
        aen = 1'b0;
        idle(4);

        // AEN rising mid-ACTIVE
        sa = 10'h224;
        sd = 8'h66;
        iow_n = 1'b0;
        idle(4);
        aen = 1'b1;
        idle(3);
        iow_n = 1'b1;
        idle(4);
        aen = 1'b0;
        idle(4);
        check("dma_abort_reject", reject, 1'b1);
        check("dma_abort_wr_data", wr_data, 8'hA5);
        clr_reject = 1'b1;
        idle(1);
        clr_reject = 1'b0;
        check("dma_clr_reject", reject, 1'b0);

        // back-to-back with 2 clk of iow_n high
        isa_write(10'h220, 8'h11, 3, 1'b1, 16'h0001, 4'd0, 2);
        isa_write(10'h22F, 8'h22, 3, 1'b1, 16'h8000, 4'd15, 6);
        check("b2b_wr_data", wr_data, 8'h22);
        check("b2b_wr_index", wr_index, 4'd15);
        check("b2b_reject", reject, 1'b0);

        // reset while the write is in ACTIVE
        sa = 10'h22A;
        sd = 8'hE7;
        iow_n = 1'b0;
        idle(5);
        reset = 1'b0;
        #1;
        check("rst_async_load", load, 16'h0000);
        check("rst_async_wr_data", wr_data, 8'h00);
        idle(2);
        reset = 1'b1;
        #1 iow_n = 1'b1;
        idle(8);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_wr_index", wr_index, 4'd0);
        check("rst_load", load, 16'h0000);
        check("rst_reject", reject, 1'b0);

        idle(4);
        check("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
